// File: rtl/alu_controller.sv
// Sequencing controller for ARM data-processing instructions: latches one
// instruction, drives register-file reads, then ALU/shifter controls and writeback.
module alu_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] status_in,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        en_status,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_imme,
  output logic        sel_shift,
  output logic        sel_A,
  output logic        sel_B,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic        done,
  output logic        illegal
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;

  logic [3:0]  cond, opcode, rn, rd;
  logic [11:0] op2;
  logic        i_bit, s_bit;
  logic        fn, fz, fc, fv;
  logic        cond_pass, legal, no_wb, is_mov;
  logic [2:0]  alu_dec;
  logic        op_ok;
  logic [5:0]  rot;
  logic [63:0] rot_pair;

  assign cond   = instr_q[31:28];
  assign i_bit  = instr_q[25];
  assign opcode = instr_q[24:21];
  assign s_bit  = instr_q[20];
  assign rn     = instr_q[19:16];
  assign rd     = instr_q[15:12];
  assign op2    = instr_q[11:0];
  assign {fn, fz, fc, fv} = status_in[31:28];

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    alu_dec = 3'b000;
    op_ok   = 1'b1;
    case (opcode)
      4'b0000: alu_dec = 3'b010; // AND
      4'b0001: alu_dec = 3'b100; // EOR
      4'b0010: alu_dec = 3'b001; // SUB
      4'b0100: alu_dec = 3'b000; // ADD
      4'b1000: alu_dec = 3'b010; // TST
      4'b1010: alu_dec = 3'b001; // CMP
      4'b1100: alu_dec = 3'b011; // ORR
      4'b1101: alu_dec = 3'b000; // MOV
      default: op_ok   = 1'b0;
    endcase
  end

  assign no_wb  = (opcode == 4'b1000) || (opcode == 4'b1010);
  assign is_mov = (opcode == 4'b1101);
  assign legal  = op_ok && (instr_q[27:26] == 2'b00) && (cond != 4'hF) && !(no_wb && !s_bit);

  // Rotating the doubled word right leaves the rotated imm8 in the low half.
  assign rot      = {1'b0, op2[11:8], 1'b0};
  assign rot_pair = {24'd0, op2[7:0], 24'd0, op2[7:0]} >> rot;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_ready = 1'b0;
    A_addr      = 4'd0;
    B_addr      = 4'd0;
    shift_addr  = 4'd0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_S        = 1'b0;
    en_status   = 1'b0;
    shift_op    = 2'b00;
    shift_imme  = 32'd0;
    sel_shift   = 1'b0;
    sel_A       = 1'b0;
    sel_B       = 1'b0;
    imme_data   = 32'd0;
    ALU_op      = 3'b000;
    wb_en       = 1'b0;
    wb_addr     = 4'd0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        A_addr     = rn;
        B_addr     = op2[3:0];
        shift_addr = op2[11:8];
        en_A       = cond_pass && legal;
        en_B       = cond_pass && legal;
        en_S       = cond_pass && legal;
        state_d    = (cond_pass && legal) ? S_EXEC : S_DONE;
      end
      S_EXEC: begin
        ALU_op    = alu_dec;
        sel_A     = is_mov;
        sel_B     = i_bit;
        en_status = s_bit;
        wb_en     = !no_wb;
        wb_addr   = no_wb ? 4'd0 : rd;
        if (i_bit) begin
          imme_data = rot_pair[31:0];
        end else begin
          shift_op   = op2[6:5];
          sel_shift  = op2[4];
          shift_imme = op2[4] ? 32'd0 : {27'd0, op2[11:7]};
        end
        state_d = S_DONE;
      end
      default: begin
        done    = 1'b1;
        illegal = !legal;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end
endmodule
